// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-fetch path (program counter,
// instruction memory responder, decode).
//   - imem_state_e : responder FSM states (IDLE / WAIT / RESP)
//   - IMEM_ADDR_W  : default fetch/load address width
//   - IMEM_DATA_W  : default instruction word width
//   - IMEM_DEPTH   : default array depth (2**IMEM_ADDR_W words)
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_DEPTH  = 2 ** IMEM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

endpackage : imem_pkg

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// Instruction storage: synchronous write, registered read. Read and write on
// the same edge to the same word returns the old contents (read-before-write).
// Optional macro IMEM_PARITY_EN: each word carries an even-parity bit
// computed at write time; rd_parity_err is registered with rd_data.
// Ports:
//   clk, rst_n            clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data write port
//   rd_en/rd_addr         read strobe and address
//   rd_data               registered read word (reset to 0)
//   rd_parity_err         registered parity mismatch (IMEM_PARITY_EN only)
// -----------------------------------------------------------------------------
module imem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
`ifdef IMEM_PARITY_EN
    output logic              rd_parity_err,
`endif
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef IMEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] wr_word_s;
    logic [WORD_W-1:0] rd_word_s;
    logic [DATA_W-1:0] rd_data_q;
`ifdef IMEM_PARITY_EN
    logic              rd_parity_err_q;
`endif

    // Build the stored word (data plus optional parity bit).
    always_comb begin
`ifdef IMEM_PARITY_EN
        wr_word_s = {even_parity(wr_data), wr_data};
`else
        wr_word_s = wr_data;
`endif
        rd_word_s = mem_q[rd_addr];
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word_s;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q       <= {DATA_W{1'b0}};
`ifdef IMEM_PARITY_EN
            rd_parity_err_q <= 1'b0;
`endif
        end else if (rd_en) begin
            rd_data_q       <= rd_word_s[DATA_W-1:0];
`ifdef IMEM_PARITY_EN
            rd_parity_err_q <= (even_parity(rd_word_s[DATA_W-1:0]) != rd_word_s[DATA_W]);
`endif
        end
    end

    assign rd_data = rd_data_q;
`ifdef IMEM_PARITY_EN
    assign rd_parity_err = rd_parity_err_q;
`endif

endmodule : imem_array

// File: rtl/instr_fetch_responder.sv
// -----------------------------------------------------------------------------
// instr_fetch_responder
// Serves PC fetch addresses from an internal loadable instruction array after
// WAIT_STATES idle cycles, returning the word over a valid/ready channel.
// A flush drops any in-flight fetch. Optional macro IMEM_PARITY_EN adds the
// parity_err output (registered alongside resp_instr).
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   req_valid/req_ready/req_addr      fetch request channel
//   resp_valid/resp_ready             response channel handshake
//   resp_instr/resp_addr              fetched word and its address
//   flush                             abort in-flight fetch, block accept
//   load_en/load_addr/load_data       array write port (any state)
//   busy                              FSM not in IDLE
//   parity_err                        stored parity mismatch (IMEM_PARITY_EN)
// -----------------------------------------------------------------------------
module instr_fetch_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_W,
    parameter int DATA_W      = IMEM_DATA_W,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_instr,
    output logic [ADDR_W-1:0] resp_addr,
    input  logic              flush,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
`ifdef IMEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    // Counter holds WAIT_STATES-1 down to 0.
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    imem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
    logic              resp_valid_q, resp_valid_d;
    logic              ready_en_q;
    logic              accept_s;
    logic              rd_en_s;
    logic [ADDR_W-1:0] rd_addr_s;

    // State and datapath registers; ready_en_q keeps req_ready low until the
    // first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            addr_q       <= {ADDR_W{1'b0}};
            resp_addr_q  <= {ADDR_W{1'b0}};
            resp_valid_q <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            resp_addr_q  <= resp_addr_d;
            resp_valid_q <= resp_valid_d;
            ready_en_q   <= 1'b1;
        end
    end

    // Next-state logic, wait counter and array read strobe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rd_en_s   = 1'b0;
        rd_addr_s = addr_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    addr_d = req_addr;
                    if (NO_WAIT) begin
                        // Zero wait states: read on the accept edge itself.
                        state_d   = RESP;
                        rd_en_s   = 1'b1;
                        rd_addr_s = req_addr;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = RESP;
                    rd_en_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                // Flush wins over a simultaneous resp_ready; both leave RESP.
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        // resp_valid is high exactly while the registered state is RESP.
        resp_valid_d = (state_d == RESP);
        if (rd_en_s) begin
            resp_addr_d = rd_addr_s;
        end else begin
            resp_addr_d = resp_addr_q;
        end
    end

    // Output decode.
    always_comb begin
        if (ready_en_q && (state_q == IDLE) && !flush) begin
            req_ready = 1'b1;
        end else begin
            req_ready = 1'b0;
        end
        accept_s   = req_valid && req_ready;
        busy       = (state_q != IDLE);
        resp_valid = resp_valid_q;
        resp_addr  = resp_addr_q;
    end

    imem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (load_en),
        .wr_addr       (load_addr),
        .wr_data       (load_data),
        .rd_en         (rd_en_s),
        .rd_addr       (rd_addr_s),
`ifdef IMEM_PARITY_EN
        .rd_parity_err (parity_err),
`endif
        .rd_data       (resp_instr)
    );

endmodule : instr_fetch_responder
